// File: rtl/plab2_proc_fetch_buffer.sv
// Fetch buffer between the instruction memory port and the D-stage instruction register.
// Issues credit-limited imem requests, queues responses and drops wrong-path responses.
module plab2_proc_fetch_buffer #(
  parameter int unsigned p_depth = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        domain,
  input  logic        fetch_req_val,
  output logic        fetch_req_rdy,
  input  logic        squash,
  output logic        imemreq_val,
  input  logic        imemreq_rdy,
  input  logic        imemresp_val,
  output logic        imemresp_rdy,
  input  logic [31:0] imemresp_msg_data,
  output logic        inst_val_D,
  input  logic        inst_rdy_D,
  output logic [31:0] inst_data_D,
  output logic        drop_pending
);

  localparam int unsigned PtrW = (p_depth > 1) ? $clog2(p_depth) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [31:0]     mem_q [p_depth];
  logic [PtrW-1:0] head_q, tail_q;
  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] live_cnt_q, live_cnt_d;
  logic [CntW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CntW-1:0] squashed_total;
  logic [CntW:0]   occupancy;
  logic            credit_ok;
  logic            req_fire;
  logic            resp_fire;
  logic            enq;
  logic            deq;

  // Data ports carry the domain label; no logic depends on it here.
  logic unused_domain;
  assign unused_domain = domain;

  assign occupancy     = {1'b0, live_cnt_q} + {1'b0, count_q};
  assign credit_ok     = occupancy < (CntW + 1)'(p_depth);
  assign imemreq_val   = fetch_req_val & credit_ok & ~reset;
  assign fetch_req_rdy = imemreq_rdy & credit_ok & ~reset;
  assign req_fire      = imemreq_val & imemreq_rdy;
  assign resp_fire     = imemresp_val;
  assign imemresp_rdy  = 1'b1;

  assign inst_val_D   = (count_q != '0) & ~squash;
  assign deq          = inst_val_D & inst_rdy_D;
  assign inst_data_D  = (count_q != '0) ? mem_q[head_q] : '0;
  assign drop_pending = drop_cnt_q != '0;

  // Older wrong-path responses always arrive first, so they are drained before any enqueue;
  // a response with nothing outstanding is a protocol error and is ignored.
  assign enq = resp_fire & ~squash & (drop_cnt_q == '0) & (live_cnt_q != '0);

  assign squashed_total = drop_cnt_q + live_cnt_q;

  always_comb begin
    count_d    = count_q;
    live_cnt_d = live_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (squash) begin
      count_d    = '0;
      live_cnt_d = CntW'(req_fire);
      if (resp_fire && (squashed_total != '0)) begin
        drop_cnt_d = squashed_total - CntW'(1);
      end else begin
        drop_cnt_d = squashed_total;
      end
    end else begin
      if (resp_fire && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - CntW'(1);
      end
      live_cnt_d = live_cnt_q + CntW'(req_fire) - CntW'(enq);
      count_d    = count_q + CntW'(enq) - CntW'(deq);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      live_cnt_q <= '0;
      drop_cnt_q <= '0;
      for (int i = 0; i < int'(p_depth); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q    <= count_d;
      live_cnt_q <= live_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      if (squash) begin
        head_q <= '0;
        tail_q <= '0;
      end else begin
        if (enq) begin
          mem_q[tail_q] <= imemresp_msg_data;
          tail_q        <= tail_q + PtrW'(1);
        end
        if (deq) begin
          head_q <= head_q + PtrW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_plab2_proc_fetch_buffer.sv
// Directed vector bench for plab2_proc_fetch_buffer (p_depth = 2): streaming, backpressure,
// squash draining, back-to-back squashes and asynchronous reset mid-stream.
module tb_plab2_proc_fetch_buffer;

  logic        clk;
  logic        reset;
  logic        domain;
  logic        fetch_req_val;
  logic        fetch_req_rdy;
  logic        squash;
  logic        imemreq_val;
  logic        imemreq_rdy;
  logic        imemresp_val;
  logic        imemresp_rdy;
  logic [31:0] imemresp_msg_data;
  logic        inst_val_D;
  logic        inst_rdy_D;
  logic [31:0] inst_data_D;
  logic        drop_pending;

  plab2_proc_fetch_buffer #(.p_depth(2)) dut (
    .clk               (clk),
    .reset             (reset),
    .domain            (domain),
    .fetch_req_val     (fetch_req_val),
    .fetch_req_rdy     (fetch_req_rdy),
    .squash            (squash),
    .imemreq_val       (imemreq_val),
    .imemreq_rdy       (imemreq_rdy),
    .imemresp_val      (imemresp_val),
    .imemresp_rdy      (imemresp_rdy),
    .imemresp_msg_data (imemresp_msg_data),
    .inst_val_D        (inst_val_D),
    .inst_rdy_D        (inst_rdy_D),
    .inst_data_D       (inst_data_D),
    .drop_pending      (drop_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs for one cycle, the outputs expected before its edge, and the state at cycle start.
  typedef struct {
    logic        fv, mr, rv;
    logic [31:0] rd;
    logic        sq, dr;
    logic        frdy, mval, ival;
    logic [31:0] idata;
    logic        dp;
    logic [1:0]  cnt, live, drop;
  } vec_t;

  vec_t vecs[64];
  int   nv = 0;
  int   nchk = 0;
  int   nfail = 0;

  task automatic add(input logic fv, mr, rv, input logic [31:0] rd, input logic sq, dr,
                     input logic frdy, mval, ival, input logic [31:0] idata, input logic dp,
                     input logic [1:0] cnt, live, drop);
    vec_t x;
    x.fv = fv; x.mr = mr; x.rv = rv; x.rd = rd; x.sq = sq; x.dr = dr;
    x.frdy = frdy; x.mval = mval; x.ival = ival; x.idata = idata; x.dp = dp;
    x.cnt = cnt; x.live = live; x.drop = drop;
    vecs[nv] = x;
    nv++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fv, mr, rv, input logic [31:0] rd, input logic sq, dr);
    fetch_req_val     = fv;
    imemreq_rdy       = mr;
    imemresp_val      = rv;
    imemresp_msg_data = rd;
    squash            = sq;
    inst_rdy_D        = dr;
  endtask

  // A response with nothing outstanding and nothing to drop is a protocol violation.
  always @(posedge clk) begin
    if (!reset && imemresp_val) begin
      nchk++;
      if (dut.live_cnt_q == '0 && dut.drop_cnt_q == '0) begin
        nfail++;
        $display("FAIL protocol: response with live_cnt 0 and drop_cnt 0");
      end
    end
  end

  initial begin
    //   fv mr rv data     sq dr | frdy mval ival idata dp | cnt live drop
    // streaming, 1-cycle memory latency
    add(1, 1, 0, 0,       0, 1,   1, 1, 0, 0,       0,   0, 0, 0);
    add(1, 1, 1, 'h11,    0, 1,   1, 1, 0, 0,       0,   0, 1, 0);
    add(1, 1, 1, 'h22,    0, 1,   0, 0, 1, 'h11,    0,   1, 1, 0);
    add(1, 1, 0, 0,       0, 1,   1, 1, 1, 'h22,    0,   1, 0, 0);
    add(0, 1, 1, 'h33,    0, 1,   1, 0, 0, 0,       0,   0, 1, 0);
    add(0, 1, 0, 0,       0, 1,   1, 0, 1, 'h33,    0,   1, 0, 0);
    add(1, 0, 0, 0,       0, 1,   0, 1, 0, 0,       0,   0, 0, 0);
    // backpressure: two buffered, D stalled
    add(1, 1, 0, 0,       0, 0,   1, 1, 0, 0,       0,   0, 0, 0);
    add(1, 1, 1, 'h11,    0, 0,   1, 1, 0, 0,       0,   0, 1, 0);
    add(1, 1, 1, 'h22,    0, 0,   0, 0, 1, 'h11,    0,   1, 1, 0);
    add(1, 1, 0, 0,       0, 0,   0, 0, 1, 'h11,    0,   2, 0, 0);
    add(0, 1, 0, 0,       0, 1,   0, 0, 1, 'h11,    0,   2, 0, 0);
    add(0, 1, 0, 0,       0, 1,   1, 0, 1, 'h22,    0,   1, 0, 0);
    // squash with two outstanding, no request fire
    add(1, 1, 0, 0,       0, 1,   1, 1, 0, 0,       0,   0, 0, 0);
    add(1, 1, 0, 0,       0, 1,   1, 1, 0, 0,       0,   0, 1, 0);
    add(0, 1, 0, 0,       1, 1,   0, 0, 0, 0,       0,   0, 2, 0);
    add(0, 1, 1, 'hBAD0,  0, 1,   1, 0, 0, 0,       1,   0, 0, 2);
    add(0, 1, 1, 'hBAD1,  0, 1,   1, 0, 0, 0,       1,   0, 0, 1);
    add(0, 1, 0, 0,       0, 1,   1, 0, 0, 0,       0,   0, 0, 0);
    // squash masks a buffered entry and discards a same-cycle response
    add(1, 1, 0, 0,       0, 0,   1, 1, 0, 0,       0,   0, 0, 0);
    add(0, 1, 1, 'h55,    0, 0,   1, 0, 0, 0,       0,   0, 1, 0);
    add(1, 1, 0, 0,       0, 0,   1, 1, 1, 'h55,    0,   1, 0, 0);
    add(1, 1, 1, 'h66,    1, 1,   0, 0, 0, 'h55,    0,   1, 1, 0);
    add(0, 1, 0, 0,       0, 1,   1, 0, 0, 0,       0,   0, 0, 0);
    // squash while the target request fires: one dropped, then 0x44 delivered
    add(1, 1, 0, 0,       0, 1,   1, 1, 0, 0,       0,   0, 0, 0);
    add(1, 1, 0, 0,       1, 1,   1, 1, 0, 0,       0,   0, 1, 0);
    add(0, 1, 1, 'hDEAD,  0, 1,   1, 0, 0, 0,       1,   0, 1, 1);
    add(0, 1, 1, 'h44,    0, 1,   1, 0, 0, 0,       0,   0, 1, 0);
    add(0, 1, 0, 0,       0, 1,   1, 0, 1, 'h44,    0,   1, 0, 0);
    // back-to-back squashes
    add(1, 1, 0, 0,       0, 1,   1, 1, 0, 0,       0,   0, 0, 0);
    add(1, 1, 0, 0,       1, 1,   1, 1, 0, 0,       0,   0, 1, 0);
    add(1, 1, 0, 0,       1, 1,   1, 1, 0, 0,       1,   0, 1, 1);
    add(0, 1, 1, 'hBAD2,  0, 1,   1, 0, 0, 0,       1,   0, 1, 2);
    add(0, 1, 1, 'hBAD3,  0, 1,   1, 0, 0, 0,       1,   0, 1, 1);
    add(0, 1, 1, 'h77,    0, 1,   1, 0, 0, 0,       0,   0, 1, 0);
    add(0, 1, 0, 0,       0, 1,   1, 0, 1, 'h77,    0,   1, 0, 0);
    // build up state ahead of a mid-stream reset
    add(1, 1, 0, 0,       0, 1,   1, 1, 0, 0,       0,   0, 0, 0);
    add(0, 1, 1, 'h88,    0, 1,   1, 0, 0, 0,       0,   0, 1, 0);
    add(1, 1, 0, 0,       0, 0,   1, 1, 1, 'h88,    0,   1, 0, 0);
    add(1, 1, 0, 0,       0, 0,   0, 0, 1, 'h88,    0,   1, 1, 0);

    domain = 1'b0;
    reset  = 1'b1;
    drive(1, 1, 0, 0, 0, 1);
    #1;
    chk("reset frdy", 32'(fetch_req_rdy), 0);
    chk("reset mval", 32'(imemreq_val), 0);
    chk("reset ival", 32'(inst_val_D), 0);
    chk("reset dp", 32'(drop_pending), 0);
    chk("reset resp_rdy", 32'(imemresp_rdy), 1);
    chk("reset idata", inst_data_D, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    drive(0, 1, 0, 0, 0, 1);

    for (int i = 0; i < nv; i++) begin
      @(negedge clk);
      drive(vecs[i].fv, vecs[i].mr, vecs[i].rv, vecs[i].rd, vecs[i].sq, vecs[i].dr);
      #1;
      chk($sformatf("v%0d frdy", i), 32'(fetch_req_rdy), 32'(vecs[i].frdy));
      chk($sformatf("v%0d mval", i), 32'(imemreq_val), 32'(vecs[i].mval));
      chk($sformatf("v%0d ival", i), 32'(inst_val_D), 32'(vecs[i].ival));
      chk($sformatf("v%0d idata", i), inst_data_D, vecs[i].idata);
      chk($sformatf("v%0d dp", i), 32'(drop_pending), 32'(vecs[i].dp));
      chk($sformatf("v%0d count", i), 32'(dut.count_q), 32'(vecs[i].cnt));
      chk($sformatf("v%0d live", i), 32'(dut.live_cnt_q), 32'(vecs[i].live));
      chk($sformatf("v%0d drop", i), 32'(dut.drop_cnt_q), 32'(vecs[i].drop));
    end

    // asynchronous reset between edges with one buffered and one outstanding
    @(negedge clk);
    drive(1, 1, 0, 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    chk("areset frdy", 32'(fetch_req_rdy), 0);
    chk("areset mval", 32'(imemreq_val), 0);
    chk("areset ival", 32'(inst_val_D), 0);
    chk("areset idata", inst_data_D, 0);
    chk("areset dp", 32'(drop_pending), 0);
    chk("areset resp_rdy", 32'(imemresp_rdy), 1);
    chk("areset count", 32'(dut.count_q), 0);
    chk("areset live", 32'(dut.live_cnt_q), 0);

    @(negedge clk);
    reset = 1'b0;
    drive(1, 1, 0, 0, 0, 1);
    #1;
    chk("resume frdy", 32'(fetch_req_rdy), 1);
    chk("resume mval", 32'(imemreq_val), 1);
    chk("resume ival", 32'(inst_val_D), 0);
    @(negedge clk);
    drive(0, 1, 1, 'h99, 0, 1);
    #1;
    chk("resume live", 32'(dut.live_cnt_q), 1);
    chk("resume ival2", 32'(inst_val_D), 0);
    @(negedge clk);
    drive(0, 1, 0, 0, 0, 1);
    #1;
    chk("resume deliver val", 32'(inst_val_D), 1);
    chk("resume deliver data", inst_data_D, 'h99);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
